// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern pipe-out source and its checker.
// Both ends import this package so they generate and expect the same
// word sequences for every pattern mode.
package pattern_pkg;

    // Default word width of the pattern stream.
    localparam int PAT_DATA_W = 32;

    // Galois LFSR feedback mask that the LFSR pattern uses.
    localparam logic [31:0] LFSR_POLY_DEFAULT = 32'h80200003;

    // Pattern select encodings, as written by the host through a wire endpoint.
    typedef enum logic [1:0] {
        PAT_COUNTER  = 2'd0,
        PAT_WALK_ONE = 2'd1,
        PAT_LFSR     = 2'd2,
        PAT_CONST    = 2'd3
    } pattern_sel_t;

    // Source control states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_RUN   = 2'd2
    } pipe_state_t;

    // Walking-one and LFSR patterns lock up on an all-zero value, so a zero
    // seed has to be replaced with 1 when one of them is selected.
    function automatic logic seed_needs_nonzero(input pattern_sel_t mode);
        return (mode == PAT_WALK_ONE) || (mode == PAT_LFSR);
    endfunction

endpackage

// File: rtl/pattern_pipeout_source_if.sv
// okPipeOut-side handshake between the pattern source and the pipe-out
// endpoint: the endpoint strobes ep_read, the source presents the head word.
interface pattern_pipeout_source_if #(
    parameter int DATA_W = 32
);
    logic              ep_read;
    logic [DATA_W-1:0] ep_datain;
    logic              ready;

    // Source side: serves words, consumes read strobes.
    modport master (
        input  ep_read,
        output ep_datain,
        output ready
    );

    // Endpoint side: issues read strobes, receives words.
    modport slave (
        output ep_read,
        input  ep_datain,
        input  ready
    );
endinterface

// File: rtl/pattern_step.sv
// Combinational next-value function of the pattern generator.
// The checker instantiates the same block so both sides step identically.
module pattern_step
    import pattern_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(LFSR_POLY_DEFAULT)
) (
    input  pattern_sel_t      mode,
    input  logic [DATA_W-1:0] v,
    output logic [DATA_W-1:0] v_next
);

    // Advance the current value by one step of the selected pattern.
    always_comb begin
        v_next = v;
        case (mode)
            PAT_COUNTER:  v_next = v + DATA_W'(1);
            PAT_WALK_ONE: v_next = {v[DATA_W-2:0], v[DATA_W-1]};
            PAT_LFSR:     v_next = (v >> 1) ^ (v[0] ? LFSR_POLY : '0);
            PAT_CONST:    v_next = v;
            default:      v_next = v;
        endcase
    end

endmodule

// File: rtl/pattern_pipeout_source.sv
// Pattern pipe-out source: generates a known word sequence into a small
// prefetch buffer and serves it first-word-fall-through to an okPipeOut
// endpoint, with delivered-word and underrun statistics for the host.
module pattern_pipeout_source
    import pattern_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 16,
    parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(LFSR_POLY_DEFAULT),
    localparam int               PTR_W     = $clog2(DEPTH),
    localparam int               LVL_W     = PTR_W + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      restart,
    input  logic [1:0]                pattern_sel,
    input  logic [DATA_W-1:0]         seed,
    pattern_pipeout_source_if.master  pipe,
    output logic [LVL_W-1:0]          fill_level,
    output logic [31:0]               word_count,
    output logic [31:0]               underrun_count
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    pipe_state_t       state_reg;
    pipe_state_t       state_next;
    pattern_sel_t      mode_reg;
    logic [DATA_W-1:0] gen_reg;
    logic [DATA_W-1:0] gen_step;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;
    logic [31:0]       word_count_reg;
    logic [31:0]       underrun_count_reg;

    // Prefetch storage; written one word per push, read asynchronously at
    // the head pointer so the endpoint sees data without read latency.
    logic [DATA_W-1:0] mem [DEPTH];

    // Per-cycle control decisions from the FSM.
    logic              do_load;
    logic              do_push;
    logic              do_pop;
    logic              do_underrun;
    logic              buf_empty;
    logic              buf_full;

    // Seed as it will be loaded, with the zero-lockup case patched.
    pattern_sel_t      sel_in;
    logic [DATA_W-1:0] seed_load;

    assign sel_in    = pattern_sel_t'(pattern_sel);
    assign seed_load = (seed_needs_nonzero(sel_in) && (seed == '0)) ? DATA_W'(1) : seed;

    assign buf_empty = (level_reg == '0);
    assign buf_full  = (level_reg == LVL_W'(DEPTH));

    // ------------------------------------------------------------------
    // Pattern generator step
    // ------------------------------------------------------------------
    pattern_step #(
        .DATA_W    (DATA_W),
        .LFSR_POLY (LFSR_POLY)
    ) u_step (
        .mode   (mode_reg),
        .v      (gen_reg),
        .v_next (gen_step)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and per-cycle buffer actions; restart overrides everything,
    // including a read strobe in the same cycle.
    always_comb begin
        state_next  = state_reg;
        do_load     = 1'b0;
        do_push     = 1'b0;
        do_pop      = 1'b0;
        do_underrun = 1'b0;
        if (restart) begin
            state_next = S_FLUSH;
            do_load    = 1'b1;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    // Buffer is always empty before the first restart.
                    do_underrun = pipe.ep_read;
                end
                S_FLUSH: begin
                    state_next = S_RUN;
                end
                S_RUN: begin
                    do_pop      = pipe.ep_read && !buf_empty;
                    do_underrun = pipe.ep_read && buf_empty;
                    do_push     = !buf_full || do_pop;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Generator value and latched mode: reload on restart, step on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_reg  <= '0;
            mode_reg <= PAT_COUNTER;
        end else if (do_load) begin
            gen_reg  <= seed_load;
            mode_reg <= sel_in;
        end else if (do_push) begin
            gen_reg  <= gen_step;
        end
    end

    // Buffer write port; contents need no reset because the level gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= gen_reg;
        end
    end

    // Pointers and fill level; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (do_load) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Saturating delivered-word and underrun statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count_reg     <= '0;
            underrun_count_reg <= '0;
        end else if (do_load) begin
            word_count_reg     <= '0;
            underrun_count_reg <= '0;
        end else begin
            if (do_pop && (word_count_reg != '1)) begin
                word_count_reg <= word_count_reg + 32'd1;
            end
            if (do_underrun && (underrun_count_reg != '1)) begin
                underrun_count_reg <= underrun_count_reg + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pipe.ep_datain = buf_empty ? '0 : mem[rd_ptr_reg];
    assign pipe.ready     = !buf_empty;
    assign fill_level     = level_reg;
    assign word_count     = word_count_reg;
    assign underrun_count = underrun_count_reg;

endmodule

// File: tb/tb_pattern_pipeout_source.sv
// Scoreboard bench for pattern_pipeout_source: the stimulus queues the word
// each read should return, a negedge monitor checks every read strobe.
module tb_pattern_pipeout_source;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b1;
    logic        restart     = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [31:0] seed        = 32'd0;
    logic [4:0]  fill_level;
    logic [31:0] word_count;
    logic [31:0] underrun_count;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q[$];
    logic        expect_valid = 1'b0;

    pattern_pipeout_source_if #(.DATA_W(DATA_W)) pipe ();

    pattern_pipeout_source #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .restart        (restart),
        .pattern_sel    (pattern_sel),
        .seed           (seed),
        .pipe           (pipe),
        .fill_level     (fill_level),
        .word_count     (word_count),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every read strobe that will land on the next edge is checked
    // against the scoreboard (expected data) or as an underrun (empty output).
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n && pipe.ep_read && !restart) begin
            if (expect_valid) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL scoreboard_empty: read with no expected word queued");
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] read  data=%h expected=%h ready=%0b", pipe.ep_datain, e, pipe.ready);
                    check("read_ready", {31'd0, pipe.ready}, 32'd1);
                    check("read_data", pipe.ep_datain, e);
                end
            end else begin
                $display("[TB] empty read data=%h ready=%0b", pipe.ep_datain, pipe.ready);
                check("empty_ready", {31'd0, pipe.ready}, 32'd0);
                check("empty_data", pipe.ep_datain, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_restart(input logic [1:0] sel, input logic [31:0] sd);
        pattern_sel = sel;
        seed        = sd;
        restart     = 1'b1;
        tick();
        restart     = 1'b0;
        check("restart_word_count", word_count, 32'd0);
        check("restart_underrun", underrun_count, 32'd0);
        check("restart_fill", {27'd0, fill_level}, 32'd0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!pipe.ready && n < 20) begin
            tick();
            n++;
        end
        check("wait_ready", {31'd0, pipe.ready}, 32'd1);
    endtask

    // kind: 0 counter from base, 1 walking one, 2 LFSR from base, 3 constant base.
    task automatic burst(input int n, input int kind, input logic [31:0] base);
        logic [31:0] v;
        logic [31:0] e;
        v = base;
        for (int i = 0; i < n; i++) begin
            case (kind)
                0: e = base + 32'(i);
                1: e = 32'h1 << (i % 32);
                2: begin
                    e = v;
                    v = (v >> 1) ^ (v[0] ? 32'h80200003 : 32'h0);
                end
                default: e = base;
            endcase
            exp_q.push_back(e);
            pipe.ep_read = 1'b1;
            expect_valid = 1'b1;
            tick();
        end
        pipe.ep_read = 1'b0;
        expect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pipe.ep_read = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state.
        check("reset_fill", {27'd0, fill_level}, 32'd0);
        check("reset_ready", {31'd0, pipe.ready}, 32'd0);
        check("reset_data", pipe.ep_datain, 32'd0);
        check("reset_word_count", word_count, 32'd0);
        check("reset_underrun", underrun_count, 32'd0);

        // Reads before any restart are underruns.
        pipe.ep_read = 1'b1;
        repeat (5) tick();
        pipe.ep_read = 1'b0;
        check("idle_underrun", underrun_count, 32'd5);
        check("idle_word_count", word_count, 32'd0);
        check("idle_data", pipe.ep_datain, 32'd0);

        // Counter pattern, 40 back-to-back reads.
        do_restart(2'd0, 32'h10);
        wait_ready();
        burst(40, 0, 32'h10);
        check("counter_word_count", word_count, 32'd40);
        check("counter_underrun", underrun_count, 32'd0);

        // Walking one from zero seed, wraps after 32 words.
        do_restart(2'd1, 32'h0);
        wait_ready();
        burst(34, 1, 32'h0);
        check("walk_word_count", word_count, 32'd34);

        // LFSR from seed 1: 1, 0x80200003, 0xC0300002, ...
        do_restart(2'd2, 32'h1);
        wait_ready();
        burst(20, 2, 32'h1);
        check("lfsr_word_count", word_count, 32'd20);

        // Let the buffer fill, then drain at full rate with no gaps.
        do_restart(2'd0, 32'h100);
        repeat (100) tick();
        check("full_fill", {27'd0, fill_level}, 32'd16);
        check("full_ready", {31'd0, pipe.ready}, 32'd1);
        burst(30, 0, 32'h100);
        check("full_after_fill", {27'd0, fill_level}, 32'd16);
        check("full_word_count", word_count, 32'd30);

        // Restart coincident with a read mid-burst.
        do_restart(2'd0, 32'h20);
        wait_ready();
        burst(5, 0, 32'h20);
        pipe.ep_read = 1'b1;
        pattern_sel  = 2'd3;
        seed         = 32'hA5A5A5A5;
        restart      = 1'b1;
        tick();
        restart      = 1'b0;
        pipe.ep_read = 1'b0;
        check("rs_word_count", word_count, 32'd0);
        check("rs_underrun", underrun_count, 32'd0);
        check("rs_fill", {27'd0, fill_level}, 32'd0);
        wait_ready();
        burst(10, 3, 32'hA5A5A5A5);
        check("const_word_count", word_count, 32'd10);
        check("const_underrun", underrun_count, 32'd0);

        // Asynchronous reset in the middle of a burst.
        do_restart(2'd0, 32'h40);
        wait_ready();
        burst(4, 0, 32'h40);
        pipe.ep_read = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("arst_ready", {31'd0, pipe.ready}, 32'd0);
        check("arst_data", pipe.ep_datain, 32'd0);
        check("arst_fill", {27'd0, fill_level}, 32'd0);
        check("arst_word_count", word_count, 32'd0);
        pipe.ep_read = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("post_rst_ready", {31'd0, pipe.ready}, 32'd0);
        check("post_rst_fill", {27'd0, fill_level}, 32'd0);
        pipe.ep_read = 1'b1;
        repeat (2) tick();
        pipe.ep_read = 1'b0;
        check("post_rst_underrun", underrun_count, 32'd2);
        check("post_rst_word_count", word_count, 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
